count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Receive-side companion to the 4-bit free-running counter: it samples a count bus driven by an upstream counter, tracks the expected next value, and declares lock after a run of correct increments. Once locked, it flags every sequence break, counts errors in a saturating register, and pulses on each wrap (all-ones to zero). It sits at the consumer end of any counter-driven link and serves both as a run-time integrity monitor and as a self-checking element in counter benches.

## Interface
- WIDTH, 4: width of the observed count bus.
- LOCK_CNT, 3: consecutive correct increments required to enter LOCKED; legal range 1 to 15.
- ERR_W, 8: width of the error counter.

- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high; clears all state.
- in_valid  input  1  count_in is sampled only when high.
- count_in  input  WIDTH  observed counter value.
- clr  input  1  synchronous clear of err_count only.
- locked  output  1  high while in LOCKED.
- expected  output  WIDTH  registered next value expected (prev + 1 mod 2^WIDTH).
- err_pulse  output  1  one-cycle pulse on a mismatch while LOCKED.
- wrap_pulse  output  1  one-cycle pulse on a correct all-ones to 0 transition while LOCKED.
- err_count  output  ERR_W  saturating count of err_pulse events.

## Operation
- Internal state: prev (WIDTH), have_prev (1), run_len (4 bits, saturating at LOCK_CNT), fsm in {SYNC, LOCKED}.
- Match means count_in == prev + 1, computed modulo 2^WIDTH; 15 followed by 0 is a match for WIDTH = 4.
- When in_valid is low, all state holds, and err_pulse and wrap_pulse are 0.
- SYNC, on a valid sample:
  - If have_prev = 0: load prev, set have_prev, keep run_len = 0.
  - Otherwise: on a match, run_len increments; on a mismatch, run_len resets to 0. prev loads count_in in both cases.
  - When run_len reaches LOCK_CNT on this sample, go to LOCKED. No error is ever flagged in SYNC.
- LOCKED, on a valid sample:
  - Match: prev loads count_in, state stays LOCKED. If count_in == 0, assert wrap_pulse.
  - Mismatch: assert err_pulse, increment err_count (saturating at 2^ERR_W - 1), load prev = count_in, clear run_len, go to SYNC. The bad value becomes the new reference for relock.
- expected always equals prev + 1 (mod 2^WIDTH). It is meaningful only when have_prev = 1 and reads 1 after reset.
- clr: err_count becomes 0 on the next edge. If clr and an error occur in the same cycle, clr wins (err_count = 0) but err_pulse still asserts.
- err_count saturated: further errors still pulse err_pulse, and the count stays at its maximum.

## Timing
- Reset values: locked = 0, expected = 1 (prev = 0), err_pulse = 0, wrap_pulse = 0, err_count = 0, have_prev = 0, run_len = 0, fsm = SYNC.
- Reset takes effect immediately on assertion, without waiting for a clock edge. Reset mid-stream discards lock; the first valid sample after release only primes prev.
- All outputs are registered, with one-cycle latency from the sampling edge:
  - err_pulse, wrap_pulse and the new err_count are visible after the same edge that samples the offending or wrapping value.
  - locked rises after the edge that samples the LOCK_CNT-th correct increment.
  - locked falls after the edge that samples the first mismatch.
- Lock time from reset with continuous valid and a clean stream: LOCK_CNT + 1 samples.
- Gaps in in_valid do not break the sequence; only sampled values are compared.

## Test plan
- Lock: reset, then drive 0,1,2,3 with in_valid high every cycle (LOCK_CNT = 3) -> locked rises after the edge sampling 3; err_count stays 0.
- Wrap: locked stream 13,14,15,0,1 -> exactly one wrap_pulse, after the edge sampling 0; no err_pulse.
- Break and relock: locked, then feed 5,6,9,10,11,12 -> err_pulse and err_count = 1 after sampling 9, locked drops; locked returns after sampling 12.
- in_valid gaps: locked stream 4,5 then in_valid low for 3 cycles with count_in = 0xA, then 6 -> no error, locked held, expected = 7.
- Saturation and clr: with ERR_W = 2, force 5 errors (relocking between each) -> err_count sticks at 3 while err_pulse fires 5 times; then assert clr on the same cycle as a 6th error -> err_count = 0 and err_pulse = 1.
- Async reset: assert rst between clock edges while locked with err_count = 2 -> locked = 0 and err_count = 0 before the next edge; after release, sample 7 then 8 -> still unlocked, run_len = 1.

Source files
------------

// File: rtl/count_seq_if.sv
// Observation bus between a counter-driven link and its sequence checker.
// Strict valid semantics: count_in is meaningful only in a cycle where in_valid is high; there is no back-pressure.
interface count_seq_if #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] count_in;
  logic             clr;
  logic             locked;
  logic [WIDTH-1:0] expected;
  logic             err_pulse;
  logic             wrap_pulse;
  logic [ERR_W-1:0] err_count;
  // Debug view of the checker's internal tracking state.
  logic             state_dbg;
  logic [3:0]       run_len_dbg;
  logic             have_prev_dbg;

  modport master (
    output in_valid, count_in, clr,
    input  locked, expected, err_pulse, wrap_pulse, err_count,
    input  state_dbg, run_len_dbg, have_prev_dbg
  );

  modport slave (
    input  in_valid, count_in, clr,
    output locked, expected, err_pulse, wrap_pulse, err_count,
    output state_dbg, run_len_dbg, have_prev_dbg
  );
endinterface

// File: rtl/count_seq_checker.sv
// Tracks an upstream free-running counter, locks after LOCK_CNT clean increments,
// then flags sequence breaks (saturating error count) and pulses on each wrap.
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  count_seq_if.slave  bus
);

  typedef enum logic {SYNC = 1'b0, LOCKED = 1'b1} state_e;

  localparam logic [3:0]       LOCK_V  = 4'(LOCK_CNT);
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] expected_q;
  logic             have_prev_q;
  logic [3:0]       run_len_q;
  logic [3:0]       run_len_d;
  logic             err_pulse_q;
  logic             wrap_pulse_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic             match;

  // expected_q is kept as prev_q + 1 so the match compare needs no adder.
  always_comb begin
    match       = (bus.count_in == expected_q);
    run_len_d   = '0;
    if (match) run_len_d = (run_len_q >= LOCK_V) ? LOCK_V : run_len_q + 4'd1;
    err_count_d = (err_count_q == '1) ? err_count_q : err_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SYNC;
      prev_q       <= '0;
      expected_q   <= ONE_W;
      have_prev_q  <= 1'b0;
      run_len_q    <= '0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      if (bus.in_valid) begin
        prev_q      <= bus.count_in;
        expected_q  <= bus.count_in + ONE_W;
        have_prev_q <= 1'b1;
        case (state_q)
          SYNC: begin
            if (have_prev_q) begin
              run_len_q <= run_len_d;
              if (run_len_d == LOCK_V) state_q <= LOCKED;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_pulse_q <= (bus.count_in == '0);
            end else begin
              // The bad value becomes the reference for relocking.
              err_pulse_q <= 1'b1;
              err_count_q <= err_count_d;
              run_len_q   <= '0;
              state_q     <= SYNC;
            end
          end
          default: state_q <= SYNC;
        endcase
      end
      if (bus.clr) err_count_q <= '0;
    end
  end

  assign bus.locked        = (state_q == LOCKED);
  assign bus.expected      = expected_q;
  assign bus.err_pulse     = err_pulse_q;
  assign bus.wrap_pulse    = wrap_pulse_q;
  assign bus.err_count     = err_count_q;
  assign bus.state_dbg     = state_q;
  assign bus.run_len_dbg   = run_len_q;
  assign bus.have_prev_dbg = have_prev_q;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: vector table, multi-cycle corner sequences, then
// random traffic checked against an arithmetic reference model.
module tb_count_seq_checker;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 2;
  localparam int MOD      = 1 << WIDTH;
  localparam int ERR_MAX  = (1 << ERR_W) - 1;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  count_seq_if #(.WIDTH(WIDTH), .ERR_W(ERR_W)) bus ();

  count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_prev, m_run, m_ec;
  bit m_have, m_locked, m_errp, m_wrapp;

  function automatic void model_reset();
    m_prev = 0; m_run = 0; m_ec = 0;
    m_have = 0; m_locked = 0; m_errp = 0; m_wrapp = 0;
  endfunction

  function automatic void model_step(bit v, int c, bit cl);
    bit hit;
    m_errp  = 0;
    m_wrapp = 0;
    if (v) begin
      if (!m_have) begin
        m_have = 1;
      end else begin
        hit = (c == (m_prev + 1) % MOD);
        if (!m_locked) begin
          m_run = hit ? ((m_run + 1 > LOCK_CNT) ? LOCK_CNT : m_run + 1) : 0;
          if (m_run == LOCK_CNT) m_locked = 1;
        end else if (hit) begin
          m_wrapp = (c == 0);
        end else begin
          m_errp   = 1;
          m_ec     = (m_ec + 1 > ERR_MAX) ? ERR_MAX : m_ec + 1;
          m_run    = 0;
          m_locked = 0;
        end
      end
      m_prev = c;
    end
    if (cl) m_ec = 0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".locked"},   int'(bus.locked),      int'(m_locked));
    chk({tag, ".expected"}, int'(bus.expected),    (m_prev + 1) % MOD);
    chk({tag, ".err_pulse"},int'(bus.err_pulse),   int'(m_errp));
    chk({tag, ".wrap"},     int'(bus.wrap_pulse),  int'(m_wrapp));
    chk({tag, ".err_count"},int'(bus.err_count),   m_ec);
    chk({tag, ".run_len"},  int'(bus.run_len_dbg), m_run);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.count_in = '0; bus.clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(bit v, int c, bit cl, string tag);
    @(negedge clk);
    bus.in_valid = v;
    bus.count_in = WIDTH'(c);
    bus.clr      = cl;
    @(posedge clk);
    #1;
    model_step(v, c, cl);
    chk_model(tag);
  endtask

  // Relock from the current reference with LOCK_CNT clean increments.
  task automatic relock(string tag);
    for (int i = 0; i < LOCK_CNT; i++) step(1'b1, (m_prev + 1) % MOD, 1'b0, tag);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit v; int c; bit cl;
    bit e_lock; int e_exp; bit e_err; bit e_wrap; int e_ec;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit v, int c, bit cl, bit l, int e, bit ep, bit w, int ec);
    vec_t r;
    r.v = v; r.c = c; r.cl = cl;
    r.e_lock = l; r.e_exp = e; r.e_err = ep; r.e_wrap = w; r.e_ec = ec;
    vecs.push_back(r);
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_valid = 1'b0; bus.count_in = '0; bus.clr = 1'b0;
    model_reset();
    #12;
    chk("reset.locked",    int'(bus.locked),     0);
    chk("reset.expected",  int'(bus.expected),   1);
    chk("reset.err_pulse", int'(bus.err_pulse),  0);
    chk("reset.wrap",      int'(bus.wrap_pulse), 0);
    chk("reset.err_count", int'(bus.err_count),  0);
    chk("reset.have_prev", int'(bus.have_prev_dbg), 0);
    @(negedge clk);
    rst = 1'b0;

    // Lock: 0,1,2,3 -> locked only after the 3rd increment
    step(1, 0, 0, "lock0"); chk("lock0.l", int'(bus.locked), 0);
    step(1, 1, 0, "lock1"); chk("lock1.l", int'(bus.locked), 0);
    step(1, 2, 0, "lock2"); chk("lock2.l", int'(bus.locked), 0);
    step(1, 3, 0, "lock3"); chk("lock3.l", int'(bus.locked), 1);
    chk("lock3.ec", int'(bus.err_count), 0);

    // Table: lock from 10, wrap, gaps, break and relock, clr
    do_reset();
    add(1,10,0, 0,11,0,0,0); add(1,11,0, 0,12,0,0,0); add(1,12,0, 0,13,0,0,0);
    add(1,13,0, 1,14,0,0,0); add(1,14,0, 1,15,0,0,0); add(1,15,0, 1, 0,0,0,0);
    add(1, 0,0, 1, 1,0,1,0); add(1, 1,0, 1, 2,0,0,0); add(0,10,0, 1, 2,0,0,0);
    add(1, 2,0, 1, 3,0,0,0); add(1, 3,0, 1, 4,0,0,0); add(1, 4,0, 1, 5,0,0,0);
    add(1, 5,0, 1, 6,0,0,0); add(0,10,0, 1, 6,0,0,0); add(0,10,0, 1, 6,0,0,0);
    add(0,10,0, 1, 6,0,0,0); add(1, 6,0, 1, 7,0,0,0); add(1, 9,0, 0,10,1,0,1);
    add(1,10,0, 0,11,0,0,1); add(1,11,0, 0,12,0,0,1); add(1,12,0, 1,13,0,0,1);
    add(1,13,1, 1,14,0,0,0); add(1,14,0, 1,15,0,0,0);
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].c, vecs[i].cl, "tblm");
      chk($sformatf("tbl[%0d].locked", i),   int'(bus.locked),     int'(vecs[i].e_lock));
      chk($sformatf("tbl[%0d].expected", i), int'(bus.expected),   vecs[i].e_exp);
      chk($sformatf("tbl[%0d].err", i),      int'(bus.err_pulse),  int'(vecs[i].e_err));
      chk($sformatf("tbl[%0d].wrap", i),     int'(bus.wrap_pulse), int'(vecs[i].e_wrap));
      chk($sformatf("tbl[%0d].ec", i),       int'(bus.err_count),  vecs[i].e_ec);
    end

    // Saturation: 5 errors with relock between, count sticks at max
    for (int k = 1; k <= 5; k++) begin
      step(1, (m_prev + 5) % MOD, 0, "sat");
      chk($sformatf("sat%0d.err", k), int'(bus.err_pulse), 1);
      chk($sformatf("sat%0d.ec", k),  int'(bus.err_count), (k > ERR_MAX) ? ERR_MAX : k);
      relock("satrl");
    end
    step(1, (m_prev + 7) % MOD, 1, "clrerr");
    chk("clrerr.err", int'(bus.err_pulse), 1);
    chk("clrerr.ec",  int'(bus.err_count), 0);

    // Async reset while locked with err_count = 2
    relock("ar");
    step(1, (m_prev + 3) % MOD, 0, "ar_e1"); relock("ar");
    step(1, (m_prev + 3) % MOD, 0, "ar_e2"); relock("ar");
    chk("ar.pre_locked", int'(bus.locked),    1);
    chk("ar.pre_ec",     int'(bus.err_count), 2);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("ar.locked", int'(bus.locked),    0);
    chk("ar.ec",     int'(bus.err_count), 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 7, 0, "ar7");
    step(1, 8, 0, "ar8");
    chk("ar8.locked",  int'(bus.locked),      0);
    chk("ar8.run_len", int'(bus.run_len_dbg), 1);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      bit v, cl;
      int c;
      v  = ($urandom_range(0, 9) < 8);
      cl = ($urandom_range(0, 31) == 0);
      c  = ($urandom_range(0, 9) < 8) ? (m_prev + 1) % MOD : int'($urandom_range(0, MOD - 1));
      step(v, c, cl, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
